// File: rtl/pcs_tx_scr_gearbox.sv
// 10GBASE-R transmit scrambler (1 + x^39 + x^58) plus 66b->64b gearbox.
// The scrambler acts on the payload only; the 2-bit sync header bypasses it.
module pcs_tx_scr_gearbox #(
  parameter int               DATA_W   = 64,
  parameter int               SCR_W    = 58,
  parameter logic [SCR_W-1:0] SCR_INIT = 58'h3ff_ffff_ffff_ffff,
  parameter int               SEQ_N    = 33,
  parameter int               SEQ_W    = 6
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic              head_v_i,
  input  logic [1:0]        sync_head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [SEQ_W-1:0]  seq_o,
  output logic              err_o
);

  localparam int               TAP   = 39;
  localparam logic [SEQ_W-1:0] FLUSH = SEQ_W'(SEQ_N - 1);

  logic [SEQ_W-1:0]    seq;
  logic [DATA_W-1:0]   res;
  logic [SCR_W-1:0]    scr_state;
  logic                err;
  logic                accept;
  logic                hdr_bad;
  logic [DATA_W-1:0]   scr;
  logic [SCR_W-1:0]    scr_next;
  logic [DATA_W+1:0]   blk;
  logic [2*DATA_W-1:0] cat;

  // Handshake: a block transfers on any cycle with valid_i & ready_o; the
  // encoder holds its block while ready_o is low (the flush slot, seq 32).
  assign ready_o = (seq != FLUSH);
  assign accept  = valid_i & ready_o;
  assign hdr_bad = ~head_v_i | (sync_head_i == 2'b00) | (sync_head_i == 2'b11);
  assign seq_o   = seq;
  assign err_o   = err;

  // Scrambler history: low SCR_W bits are the state (newest bit at the top),
  // followed by the freshly scrambled bits so both taps index one vector.
  always_comb begin : scramble
    logic [SCR_W+DATA_W-1:0] hist;
    hist = {{DATA_W{1'b0}}, scr_state};
    for (int i = 0; i < DATA_W; i++) begin
      hist[SCR_W+i] = data_i[i] ^ hist[SCR_W+i-TAP] ^ hist[i];
    end
    scr      = hist[SCR_W+DATA_W-1:SCR_W];
    scr_next = hist[SCR_W+DATA_W-1:DATA_W];
  end

  // At seq n the residual holds 2n bits; the new block lands just above them.
  assign blk = {scr, sync_head_i};
  assign cat = ({{(DATA_W-2){1'b0}}, blk} << {seq, 1'b0}) | {{DATA_W{1'b0}}, res};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seq       <= '0;
      res       <= '0;
      scr_state <= SCR_INIT;
      data_o    <= '0;
      valid_o   <= 1'b0;
      err       <= 1'b0;
    end else if (seq == FLUSH) begin
      data_o  <= res;
      valid_o <= 1'b1;
      res     <= '0;
      seq     <= '0;
    end else if (accept) begin
      data_o    <= cat[DATA_W-1:0];
      res       <= cat[2*DATA_W-1:DATA_W];
      scr_state <= scr_next;
      valid_o   <= 1'b1;
      seq       <= seq + SEQ_W'(1);
      if (hdr_bad) err <= 1'b1;
    end else begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcs_tx_scr_gearbox.sv
// Directed bench for pcs_tx_scr_gearbox: a zero-seed instance checked against
// hand constants and a default-seed instance checked against a bit-serial model.
module tb_pcs_tx_scr_gearbox;

  localparam logic [57:0] SEED = 58'h3ff_ffff_ffff_ffff;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0;
  logic        head_v_i = 1'b0;
  logic [1:0]  sync_head_i = 2'b00;
  logic [63:0] data_i = '0;

  logic        d0_ready, d0_valid, d0_err;
  logic [63:0] d0_data;
  logic [5:0]  d0_seq;
  logic        d1_ready, d1_valid, d1_err;
  logic [63:0] d1_data;
  logic [5:0]  d1_seq;

  pcs_tx_scr_gearbox #(.SCR_INIT(58'h0)) dut0 (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .head_v_i(head_v_i),
    .sync_head_i(sync_head_i), .data_i(data_i), .ready_o(d0_ready),
    .valid_o(d0_valid), .data_o(d0_data), .seq_o(d0_seq), .err_o(d0_err)
  );

  pcs_tx_scr_gearbox dut1 (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .head_v_i(head_v_i),
    .sync_head_i(sync_head_i), .data_i(data_i), .ready_o(d1_ready),
    .valid_o(d1_valid), .data_o(d1_data), .seq_o(d1_seq), .err_o(d1_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model for dut1: serial scrambler plus a transmit-order bit queue.
  logic [57:0] mh;
  logic        mq[$];
  logic [63:0] exp_q[$];
  int          exp_seq;
  logic [63:0] exp_data;
  logic        exp_valid, exp_err, exp_ready;
  logic        seen_ready, seen_ready0;

  task automatic model_reset();
    logic [57:0] s;
    s = SEED;
    for (int k = 0; k < 58; k++) mh[k] = s[57-k];
    mq.delete();
    exp_q.delete();
    exp_seq   = 0;
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset  = 1'b0;
    valid_i = 1'b0;
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic drive(input logic v, input logic hv, input logic [1:0] sh,
                       input logic [63:0] d);
    logic [63:0] scr;
    logic [63:0] w;
    logic        b;
    @(negedge clk);
    valid_i     = v;
    head_v_i    = hv;
    sync_head_i = sh;
    data_i      = d;
    #1;
    seen_ready  = d1_ready;
    seen_ready0 = d0_ready;
    exp_ready   = (exp_seq != 32);
    if (exp_seq == 32) begin
      for (int i = 0; i < 64; i++) w[i] = mq.pop_front();
      exp_data = w;
      exp_q.push_back(w);
      exp_valid = 1'b1;
      exp_seq   = 0;
    end else if (v) begin
      for (int i = 0; i < 64; i++) begin
        b      = d[i] ^ mh[38] ^ mh[57];
        scr[i] = b;
        mh     = {mh[56:0], b};
      end
      mq.push_back(sh[0]);
      mq.push_back(sh[1]);
      for (int i = 0; i < 64; i++) mq.push_back(scr[i]);
      for (int i = 0; i < 64; i++) w[i] = mq.pop_front();
      exp_data = w;
      exp_q.push_back(w);
      exp_valid = 1'b1;
      exp_seq++;
      if (!hv || sh == 2'b00 || sh == 2'b11) exp_err = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    #1;
    n_tests++; if (d1_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", d1_data); end
    n_tests++; if (d1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", d1_valid); end
    n_tests++; if (d1_seq !== 6'd0) begin n_fail++; $display("FAIL reset_seq got %0d want 0", d1_seq); end
    n_tests++; if (d1_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", d1_err); end
    n_tests++; if (d1_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", d1_ready); end
    n_tests++;
    if ({d0_data, d0_valid, d0_seq, d0_err, d0_ready} !== {64'h0, 1'b0, 6'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_dut0 got data=%h v=%b seq=%0d err=%b rdy=%b want 0/0/0/0/1",
               d0_data, d0_valid, d0_seq, d0_err, d0_ready);
    end
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_first_word();
    logic [63:0] w;
    do_reset();
    drive(1'b1, 1'b1, 2'b01, 64'h0);
    n_tests++; if (d0_data !== 64'h1) begin n_fail++; $display("FAIL first_data got %h want %h", d0_data, 64'h1); end
    n_tests++; if (d0_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", d0_valid); end
    n_tests++; if (d0_seq !== 6'd1) begin n_fail++; $display("FAIL first_seq got %0d want 1", d0_seq); end
    w = exp_q.pop_front();
    n_tests++; if (d1_data !== w) begin n_fail++; $display("FAIL first_model got %h want %h", d1_data, w); end
  endtask

  task automatic test_scr_seed();
    logic [63:0] w;
    do_reset();
    drive(1'b1, 1'b1, 2'b10, 64'h0);
    n_tests++;
    if (d1_data !== 64'h0FFF_FE00_0000_0002) begin
      n_fail++; $display("FAIL seed_word got %h want %h", d1_data, 64'h0FFF_FE00_0000_0002);
    end
    n_tests++; if (d0_data !== 64'h2) begin n_fail++; $display("FAIL seed_zero got %h want 2", d0_data); end
    w = exp_q.pop_front();
    n_tests++; if (d1_data !== w) begin n_fail++; $display("FAIL seed_model got %h want %h", d1_data, w); end
  endtask

  task automatic test_full_sequence();
    int          p;
    logic [63:0] w0, w;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      p = c % 33;
      drive(1'b1, 1'b1, 2'b01, 64'h0);
      w0 = (p == 32) ? 64'h0 : (64'h1 << (2 * p));
      n_tests++; if (seen_ready0 !== (p != 32)) begin n_fail++; $display("FAIL full_ready c=%0d got %b want %b", c, seen_ready0, (p != 32)); end
      n_tests++; if (seen_ready !== exp_ready) begin n_fail++; $display("FAIL full_ready1 c=%0d got %b want %b", c, seen_ready, exp_ready); end
      n_tests++; if (d0_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid c=%0d got %b want 1", c, d0_valid); end
      n_tests++; if (d0_data !== w0) begin n_fail++; $display("FAIL full_data c=%0d got %h want %h", c, d0_data, w0); end
      n_tests++; if (d0_seq !== 6'((p + 1) % 33)) begin n_fail++; $display("FAIL full_seq c=%0d got %0d want %0d", c, d0_seq, (p + 1) % 33); end
      w = exp_q.pop_front();
      n_tests++; if (d1_data !== w) begin n_fail++; $display("FAIL full_model c=%0d got %h want %h", c, d1_data, w); end
    end
  endtask

  task automatic test_stall();
    logic [63:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 2'b01, {$urandom, $urandom});
      w = exp_q.pop_front();
      n_tests++; if (d1_data !== w) begin n_fail++; $display("FAIL stall_pre i=%0d got %h want %h", i, d1_data, w); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'b10, {$urandom, $urandom});
      n_tests++; if (d1_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid i=%0d got %b want 0", i, d1_valid); end
      n_tests++; if (d1_seq !== 6'd5) begin n_fail++; $display("FAIL stall_seq i=%0d got %0d want 5", i, d1_seq); end
      n_tests++; if (d1_data !== exp_data) begin n_fail++; $display("FAIL stall_hold i=%0d got %h want %h", i, d1_data, exp_data); end
    end
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b1, 2'($urandom_range(1, 2)), {$urandom, $urandom});
      n_tests++; if (d1_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid i=%0d got %b want 1", i, d1_valid); end
      w = exp_q.pop_front();
      n_tests++; if (d1_data !== w) begin n_fail++; $display("FAIL resume_data i=%0d got %h want %h", i, d1_data, w); end
    end
  endtask

  task automatic test_protocol_error();
    logic [63:0] w;
    do_reset();
    drive(1'b1, 1'b1, 2'b10, 64'h1234_5678_9abc_def0);
    n_tests++; if (d1_err !== 1'b0) begin n_fail++; $display("FAIL err_clean got %b want 0", d1_err); end
    void'(exp_q.pop_front());
    drive(1'b1, 1'b1, 2'b11, 64'hfedc_ba98_7654_3210);
    n_tests++; if (d1_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", d1_err); end
    w = exp_q.pop_front();
    n_tests++; if (d1_data !== w) begin n_fail++; $display("FAIL err_data got %h want %h", d1_data, w); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'b01, {$urandom, $urandom});
      n_tests++; if (d1_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky i=%0d got %b want 1", i, d1_err); end
      w = exp_q.pop_front();
      n_tests++; if (d1_data !== w) begin n_fail++; $display("FAIL err_flow i=%0d got %h want %h", i, d1_data, w); end
    end
    do_reset();
    #1;
    n_tests++; if (d1_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %b want 0", d1_err); end
    drive(1'b1, 1'b0, 2'b01, 64'h0);
    n_tests++; if (d1_err !== exp_err || d1_err !== 1'b1) begin n_fail++; $display("FAIL err_headv got %b want 1", d1_err); end
    do_reset();
    drive(1'b1, 1'b1, 2'b00, 64'h0);
    n_tests++; if (d1_err !== 1'b1) begin n_fail++; $display("FAIL err_hdr00 got %b want 1", d1_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b1, 2'b01, {$urandom, $urandom});
    n_tests++; if (d1_seq !== 6'd17) begin n_fail++; $display("FAIL mid_seq got %0d want 17", d1_seq); end
    #2;
    nreset = 1'b0;
    #1;
    n_tests++;
    if ({d1_data, d1_valid, d1_seq, d1_err, d1_ready} !== {64'h0, 1'b0, 6'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset got data=%h v=%b seq=%0d err=%b rdy=%b want 0/0/0/0/1",
               d1_data, d1_valid, d1_seq, d1_err, d1_ready);
    end
    valid_i = 1'b0;
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    drive(1'b1, 1'b1, 2'b01, 64'h0);
    n_tests++; if (d0_data !== 64'h1) begin n_fail++; $display("FAIL mid_first got %h want 1", d0_data); end
    n_tests++; if (d0_seq !== 6'd1 || d0_valid !== 1'b1) begin n_fail++; $display("FAIL mid_first_seq got seq=%0d v=%b want 1/1", d0_seq, d0_valid); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_scr_seed();
    test_full_sequence();
    test_stall();
    test_protocol_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
